// File: rtl/pipelined_modular_adder_if.sv
// Handshake bundle for the pipelined modular adder: input side (A/B/K with
// valid/ready) and output side (sum/err with valid/ready).
interface pipelined_modular_adder_if #(
    parameter int N_BITS = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] in_a;
    logic [N_BITS-1:0] in_b;
    logic [N_BITS-1:0] in_k;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out_sum;
    logic              out_err;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, in_a, in_b, in_k, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );

    // The adder itself
    modport slave (
        input  in_valid, in_a, in_b, in_k, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );
endinterface

// File: rtl/pipelined_modular_adder.sv
// Pipelined modular adder: out_sum = (A + B) mod (2^N_BITS - K).
// A+B and A+B+K are evaluated side by side (K folded in through a carry-save
// "hashed" row and a shifted "enveloped" row), each through a Sklansky prefix
// carry network; the carry-out of A+B+K picks which sum is the residue.
// Three register stages, one result per cycle, whole pipe stalls on back-pressure.
// Optional macro MODADD_RANGE_CHECK_EN adds an operand range-error flag (out_err).
module pipelined_modular_adder #(
    parameter int N_BITS = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pipelined_modular_adder_if.slave   bus
);
    localparam int PREFIX_MAX_LVL = 7;  // enough levels for N_BITS up to 128

    // Sklansky parallel prefix: returns group generate over [i:0] for every bit i
    function automatic logic [N_BITS-1:0] prefix_gen(input logic [N_BITS-1:0] g_in,
                                                     input logic [N_BITS-1:0] p_in);
        logic [N_BITS-1:0] gg;
        logic [N_BITS-1:0] pp;
        int                j;
        gg = g_in;
        pp = p_in;
        for (int l = 0; l < PREFIX_MAX_LVL; l++) begin
            if ((1 << l) < N_BITS) begin
                for (int i = N_BITS - 1; i >= 0; i--) begin
                    if (((i >> l) & 1) == 1) begin
                        // j is the top bit of the neighbouring lower block; its bit l
                        // is clear so it is not modified at this level
                        j     = ((i >> l) << l) - 1;
                        gg[i] = gg[i] | (pp[i] & gg[j]);
                        pp[i] = pp[i] & pp[j];
                    end else begin
                        gg[i] = gg[i];
                    end
                end
            end else begin
                gg = gg;
            end
        end
        return gg;
    endfunction

    logic advance_s;

    // ---------------- S1 combinational: hashed and enveloped rows ----------------
    logic [N_BITS-1:0] g_s, h_s, p_s;
    logic [N_BITS-1:0] ap_s, bp_s, bsh_s;
    logic [N_BITS-1:0] gp_s, hp_s, pp_s;

    assign g_s   = bus.in_a & bus.in_b;
    assign h_s   = bus.in_a ^ bus.in_b;
    assign p_s   = bus.in_a | bus.in_b;
    // Carry-save of A+B+K: k=1 gives sum=XNOR, carry=OR; k=0 gives XOR/AND
    assign ap_s  = (~h_s & bus.in_k) | (h_s & ~bus.in_k);
    assign bp_s  = (p_s & bus.in_k) | (g_s & ~bus.in_k);
    // Carry vector weighs one bit higher; its MSB leaves the N-bit window
    assign bsh_s = {bp_s[N_BITS-2:0], 1'b0};
    assign gp_s  = ap_s & bsh_s;
    assign hp_s  = ap_s ^ bsh_s;
    assign pp_s  = ap_s | bsh_s;

    logic              valid_s1_r;
    logic [N_BITS-1:0] g_r, h1_r, p_r, gp_r, hp1_r, pp_r;
    logic              bmsb1_r;

`ifdef MODADD_RANGE_CHECK_EN
    logic [N_BITS:0] mod_s;
    logic            err_s;
    logic            err1_r, err2_r, out_err_r;

    assign mod_s = {1'b1, {N_BITS{1'b0}}} - {1'b0, bus.in_k};
    assign err_s = ({1'b0, bus.in_a} >= mod_s) | ({1'b0, bus.in_b} >= mod_s);
`endif

    // ---------------- S2 combinational: prefix carry networks ----------------
    logic [N_BITS:0] c_s, cp_s;

    assign c_s  = {prefix_gen(g_r, p_r), 1'b0};
    assign cp_s = {prefix_gen(gp_r, pp_r), 1'b0};

    logic              valid_s2_r;
    logic [N_BITS:0]   c_r, cp_r;
    logic [N_BITS-1:0] h2_r, hp2_r;
    logic              bmsb2_r;

    // ---------------- S3 combinational: sum formation and selection ----------------
    logic [N_BITS-1:0] s0_s, s1_s, sel_sum_s;
    logic              cout_k_s;

    assign s0_s      = h2_r ^ c_r[N_BITS-1:0];
    assign s1_s      = hp2_r ^ cp_r[N_BITS-1:0];
    assign cout_k_s  = cp_r[N_BITS] | bmsb2_r;
    // A+B+K overflowing 2^N means A+B >= M, so the wrapped A+B+K-2^N is the residue
    assign sel_sum_s = cout_k_s ? s1_s : s0_s;

    logic              out_valid_r;
    logic [N_BITS-1:0] out_sum_r;

    assign advance_s     = ~out_valid_r | bus.out_ready;
    assign bus.in_ready  = advance_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;

    // Pipeline registers: all three stages move together when advance is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1_r  <= 1'b0;
            g_r         <= {N_BITS{1'b0}};
            h1_r        <= {N_BITS{1'b0}};
            p_r         <= {N_BITS{1'b0}};
            gp_r        <= {N_BITS{1'b0}};
            hp1_r       <= {N_BITS{1'b0}};
            pp_r        <= {N_BITS{1'b0}};
            bmsb1_r     <= 1'b0;
            valid_s2_r  <= 1'b0;
            c_r         <= {(N_BITS+1){1'b0}};
            cp_r        <= {(N_BITS+1){1'b0}};
            h2_r        <= {N_BITS{1'b0}};
            hp2_r       <= {N_BITS{1'b0}};
            bmsb2_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_sum_r   <= {N_BITS{1'b0}};
        end else if (advance_s) begin
            valid_s1_r  <= bus.in_valid;
            g_r         <= g_s;
            h1_r        <= h_s;
            p_r         <= p_s;
            gp_r        <= gp_s;
            hp1_r       <= hp_s;
            pp_r        <= pp_s;
            bmsb1_r     <= bp_s[N_BITS-1];
            valid_s2_r  <= valid_s1_r;
            c_r         <= c_s;
            cp_r        <= cp_s;
            h2_r        <= h1_r;
            hp2_r       <= hp1_r;
            bmsb2_r     <= bmsb1_r;
            out_valid_r <= valid_s2_r;
            out_sum_r   <= sel_sum_s;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef MODADD_RANGE_CHECK_EN
    // Range-error flag rides alongside its transaction through the stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err1_r    <= 1'b0;
            err2_r    <= 1'b0;
            out_err_r <= 1'b0;
        end else if (advance_s) begin
            err1_r    <= err_s;
            err2_r    <= err1_r;
            out_err_r <= err2_r;
        end else begin
            out_err_r <= out_err_r;
        end
    end

    assign bus.out_err = out_err_r;
`else
    assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_modular_adder.sv
// Scoreboard bench for pipelined_modular_adder (N_BITS=7): directed vectors push
// hand-computed results into a queue, a monitor pops and compares on each output.
module tb_pipelined_modular_adder;
    localparam int N = 7;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    logic       toggle_en;
    logic [3:0] pat;
    int         pidx;

    logic         stalled;
    logic [N-1:0] held_sum;

    pipelined_modular_adder_if #(.N_BITS(N)) bus ();

    pipelined_modular_adder #(.N_BITS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: fixed 1 or the repeating 1,0,0,1 pattern
    always @(posedge clk) begin
        #1;
        if (toggle_en) begin
            bus.out_ready = pat[pidx];
            pidx = (pidx + 1) % 4;
        end else begin
            bus.out_ready = 1'b1;
        end
    end

    // Monitor: handshake rule, stall stability, scoreboard pop
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            n_tests++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                n_fail++;
                $display("FAIL in_ready: got %b, required %b", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            end
            if (stalled) begin
                n_tests++;
                if (bus.out_valid !== 1'b1 || bus.out_sum !== held_sum) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b sum=%0d, required valid=1 sum=%0d", bus.out_valid, bus.out_sum, held_sum);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got sum=%0d, required no output", bus.out_sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.out_sum !== e.sum || bus.out_err !== e.err) begin
                        n_fail++;
                        $display("FAIL result: got sum=%0d err=%b, required sum=%0d err=%b", bus.out_sum, bus.out_err, e.sum, e.err);
                    end
                end
            end
            stalled  = bus.out_valid && !bus.out_ready;
            held_sum = bus.out_sum;
        end
    end

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Present one operand set, hold until accepted, then log its expected result
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] k,
                        input logic [N-1:0] s, input logic e);
        logic acc;
        exp_t x;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_k     = k;
        acc          = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0, required 1");
        end else begin
            x.sum = s;
            x.err = e;
            exp_q.push_back(x);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        toggle_en     = 1'b0;
        pat           = 4'b1001;
        pidx          = 0;
        stalled       = 1'b0;
        held_sum      = '0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_k      = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {6'd0, bus.out_valid}, 7'd0);
        check("reset_out_sum", bus.out_sum, 7'd0);
        check("reset_out_err", {6'd0, bus.out_err}, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, M = 2^7 - K
        send(7'd69,  7'd45,  7'd20, 7'd6,   1'b0);
        send(7'd50,  7'd40,  7'd20, 7'd90,  1'b0);
        send(7'd107, 7'd107, 7'd20, 7'd106, 1'b0);
        send(7'd0,   7'd0,   7'd20, 7'd0,   1'b0);
        send(7'd100, 7'd100, 7'd0,  7'd72,  1'b0);
        idle();
        drain();

        // Eight back-to-back transfers, mixed K, under 1,0,0,1 back-pressure
        pidx      = 0;
        toggle_en = 1'b1;
        send(7'd1,   7'd2,   7'd20, 7'd3,   1'b0);
        send(7'd60,  7'd60,  7'd20, 7'd12,  1'b0);
        send(7'd10,  7'd97,  7'd20, 7'd107, 1'b0);
        send(7'd100, 7'd8,   7'd20, 7'd0,   1'b0);
        send(7'd127, 7'd127, 7'd0,  7'd126, 1'b0);
        send(7'd5,   7'd6,   7'd1,  7'd11,  1'b0);
        send(7'd126, 7'd1,   7'd1,  7'd0,   1'b0);
        send(7'd63,  7'd63,  7'd64, 7'd62,  1'b0);
        idle();
        toggle_en = 1'b0;
        drain();

        // Reset while three transactions are in flight
        send(7'd30, 7'd40, 7'd20, 7'd70, 1'b0);
        send(7'd80, 7'd80, 7'd20, 7'd52, 1'b0);
        send(7'd3,  7'd4,  7'd0,  7'd7,  1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_out_valid", {6'd0, bus.out_valid}, 7'd0);
        check("midreset_out_sum", bus.out_sum, 7'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_quiet", {6'd0, bus.out_valid}, 7'd0);

        // Latency: visible in the third cycle after the accepting edge
        send(7'd69, 7'd45, 7'd20, 7'd6, 1'b0);
        idle();
        @(posedge clk);
        #1;
        check("latency_early", {6'd0, bus.out_valid}, 7'd0);
        @(posedge clk);
        #1;
        check("latency_valid", {6'd0, bus.out_valid}, 7'd1);
        check("latency_sum", bus.out_sum, 7'd6);
        drain();

`ifdef MODADD_RANGE_CHECK_EN
        send(7'd110, 7'd1, 7'd20, 7'd3,   1'b1);
        send(7'd107, 7'd0, 7'd20, 7'd107, 1'b0);
        idle();
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
